// File: rtl/gpio_n.sv
// ---------------------------------------------------------------------------
// gpio_n : parametrised GPIO slave on the ic0 single-master bus.
//
// PINS-wide bidirectional port with per-pin direction, atomic SET/CLR of the
// output register, 2-flop input synchronisation, per-pin rise/fall edge
// detection, write-1-to-clear interrupt status and a level interrupt.
// Occupies one 256-byte window at ADDR_BASE (bits [31:8] compared).
//
// Register map (word offsets, bits at and above PINS read 0):
//   0x00 OUT  RW    0x04 DIR  RW (1 = output)   0x08 IN  RO
//   0x0C RISE_EN RW 0x10 FALL_EN RW  0x14 IRQ_EN RW  0x18 STATUS W1C
//   0x1C SET  WO    0x20 CLR  WO
//
// Optional build macro GPIO_DEBOUNCE_EN: inserts a per-pin 8-bit debounce
// counter (DEB_CYCLES stable clocks) between the synchroniser and IN/edge
// logic. Undefined by default.
//
// Ports:
//   clk                     system clock, rising edge
//   c_sys_rst_n             asynchronous active-low reset
//   b_data_io[PINS]         GPIO pads
//   ic0_c_axi_mst_wr_valid  single-cycle write request
//   ic0_axi_mst_wr_addr     write byte address
//   ic0_axi_mst_wr_data     write data
//   ic0_axi_mst_wr_strobe   byte-lane enables
//   ic0_c_axi_mst_rd_valid  single-cycle read request
//   ic0_axi_mst_rd_addr     read byte address
//   ic0_c_axi_slv_rd_ready  read-data-valid pulse (1 cycle after request)
//   ic0_axi_slv_rd_data     read data (0 when rd_ready is low)
//   c_irq                   level interrupt, |(STATUS & IRQ_EN)
// ---------------------------------------------------------------------------
module gpio_n #(
  parameter int          PINS       = 8,
  parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
  parameter int          DEB_CYCLES = 4
) (
  input  logic            clk,
  input  logic            c_sys_rst_n,
  inout  wire  [PINS-1:0] b_data_io,
  input  logic            ic0_c_axi_mst_wr_valid,
  input  logic [31:0]     ic0_axi_mst_wr_addr,
  input  logic [31:0]     ic0_axi_mst_wr_data,
  input  logic [3:0]      ic0_axi_mst_wr_strobe,
  input  logic            ic0_c_axi_mst_rd_valid,
  input  logic [31:0]     ic0_axi_mst_rd_addr,
  output logic            ic0_c_axi_slv_rd_ready,
  output logic [31:0]     ic0_axi_slv_rd_data,
  output logic            c_irq
);

  localparam logic [5:0] OFF_OUT    = 6'h00;
  localparam logic [5:0] OFF_DIR    = 6'h01;
  localparam logic [5:0] OFF_IN     = 6'h02;
  localparam logic [5:0] OFF_RISE   = 6'h03;
  localparam logic [5:0] OFF_FALL   = 6'h04;
  localparam logic [5:0] OFF_IRQ_EN = 6'h05;
  localparam logic [5:0] OFF_STATUS = 6'h06;
  localparam logic [5:0] OFF_SET    = 6'h07;
  localparam logic [5:0] OFF_CLR    = 6'h08;

  // Zero-extend a pin vector onto the 32-bit bus.
  function automatic logic [31:0] widen(input logic [PINS-1:0] v);
    logic [31:0] w;
    w           = '0;
    w[PINS-1:0] = v;
    return w;
  endfunction

  // Byte-lane merge of write data into an existing register.
  function automatic logic [PINS-1:0] merge(input logic [PINS-1:0] old,
                                            input logic [31:0]     mask,
                                            input logic [31:0]     bits);
    logic [31:0] w;
    w = (widen(old) & ~mask) | bits;
    return w[PINS-1:0];
  endfunction

  // Register state
  logic [PINS-1:0] out_q, dir_q, rise_en_q, fall_en_q, irq_en_q, status_q;
  logic [PINS-1:0] out_d, dir_d, rise_en_d, fall_en_d, irq_en_d, w1c;

  // Input path
  logic [PINS-1:0] s1_q, s2_q, prev_q, lvl;
  logic [PINS-1:0] rise, fall;

  // Bus decode
  logic        wr_hit, rd_hit;
  logic [5:0]  wr_off, rd_off;
  logic [31:0] byte_mask, wr_bits;
  logic [31:0] rd_val;
  logic        unused_addr_bits;

  assign wr_hit    = ic0_c_axi_mst_wr_valid &&
                     (ic0_axi_mst_wr_addr[31:8] == ADDR_BASE[31:8]);
  assign rd_hit    = ic0_c_axi_mst_rd_valid &&
                     (ic0_axi_mst_rd_addr[31:8] == ADDR_BASE[31:8]);
  assign wr_off    = ic0_axi_mst_wr_addr[7:2];
  assign rd_off    = ic0_axi_mst_rd_addr[7:2];
  assign byte_mask = {{8{ic0_axi_mst_wr_strobe[3]}}, {8{ic0_axi_mst_wr_strobe[2]}},
                      {8{ic0_axi_mst_wr_strobe[1]}}, {8{ic0_axi_mst_wr_strobe[0]}}};
  assign wr_bits   = ic0_axi_mst_wr_data & byte_mask;

  // Byte offset bits are don't-care for word registers.
  assign unused_addr_bits = ^{ic0_axi_mst_wr_addr[1:0], ic0_axi_mst_rd_addr[1:0]};

  // ---------------------------------------------------------------------
  // Write decode
  // ---------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default before the case, so paths that do
    // not write a register hold it instead of inferring a latch.
    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    irq_en_d  = irq_en_q;
    w1c       = '0;
    if (wr_hit) begin
      case (wr_off)
        OFF_OUT:    out_d     = merge(out_q,     byte_mask, wr_bits);
        OFF_DIR:    dir_d     = merge(dir_q,     byte_mask, wr_bits);
        OFF_RISE:   rise_en_d = merge(rise_en_q, byte_mask, wr_bits);
        OFF_FALL:   fall_en_d = merge(fall_en_q, byte_mask, wr_bits);
        OFF_IRQ_EN: irq_en_d  = merge(irq_en_q,  byte_mask, wr_bits);
        OFF_STATUS: w1c       = wr_bits[PINS-1:0];
        OFF_SET:    out_d     = out_q | wr_bits[PINS-1:0];
        OFF_CLR:    out_d     = out_q & ~wr_bits[PINS-1:0];
        default:    ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Read mux (pre-write values: sampled from the current flops)
  // ---------------------------------------------------------------------
  always_comb begin
    rd_val = '0;
    case (rd_off)
      OFF_OUT:    rd_val = widen(out_q);
      OFF_DIR:    rd_val = widen(dir_q);
      OFF_IN:     rd_val = widen(lvl);
      OFF_RISE:   rd_val = widen(rise_en_q);
      OFF_FALL:   rd_val = widen(fall_en_q);
      OFF_IRQ_EN: rd_val = widen(irq_en_q);
      OFF_STATUS: rd_val = widen(status_q);
      default:    rd_val = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Optional debounce between synchroniser and level/edge logic
  // ---------------------------------------------------------------------
`ifdef GPIO_DEBOUNCE_EN
  logic [PINS-1:0] deb_q;
  logic [7:0]      cnt_q [PINS];

  always_ff @(posedge clk or negedge c_sys_rst_n) begin
    if (!c_sys_rst_n) begin
      deb_q <= '0;
      // NOTE: the counter array is only PINS entries of flops, not a RAM,
      // so it is reset with everything else to give a defined start.
      for (int i = 0; i < PINS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < PINS; i++) begin
        if (s2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == 8'(DEB_CYCLES - 1)) begin
          // DEB_CYCLES-th consecutive disagreement: accept the new level.
          deb_q[i] <= s2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 8'd1;
        end
      end
    end
  end

  assign lvl = deb_q;
`else
  assign lvl = s2_q;
`endif

  assign rise = lvl & ~prev_q & rise_en_q;
  assign fall = ~lvl & prev_q & fall_en_q;

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge c_sys_rst_n) begin
    if (!c_sys_rst_n) begin
      out_q                  <= '0;
      dir_q                  <= '0;
      rise_en_q              <= '0;
      fall_en_q              <= '0;
      irq_en_q               <= '0;
      status_q               <= '0;
      s1_q                   <= '0;
      s2_q                   <= '0;
      prev_q                 <= '0;
      ic0_c_axi_slv_rd_ready <= 1'b0;
      ic0_axi_slv_rd_data    <= '0;
    end else begin
      // NOTE: non-blocking assignments let s1 -> s2 -> prev shift as a real
      // pipeline; blocking here would collapse the synchroniser stages.
      out_q                  <= out_d;
      dir_q                  <= dir_d;
      rise_en_q              <= rise_en_d;
      fall_en_q              <= fall_en_d;
      irq_en_q               <= irq_en_d;
      // A fresh edge overrides a same-cycle clear of that bit.
      status_q               <= (status_q & ~w1c) | rise | fall;
      s1_q                   <= b_data_io;
      s2_q                   <= s1_q;
      prev_q                 <= lvl;
      ic0_c_axi_slv_rd_ready <= rd_hit;
      ic0_axi_slv_rd_data    <= rd_hit ? rd_val : '0;
    end
  end

  assign c_irq = |(status_q & irq_en_q);

  // Pads: drive only where DIR selects output, otherwise release.
  for (genvar i = 0; i < PINS; i++) begin : g_pad
    assign b_data_io[i] = dir_q[i] ? out_q[i] : 1'bz;
  end

endmodule

// File: tb/tb_gpio_n.sv
// ---------------------------------------------------------------------------
// tb_gpio_n : self-checking bench for gpio_n (PINS = 32).
// A behavioural register/pad model advances on every rising edge; a compare
// process checks rd_ready, rd_data, c_irq and driven pads on every falling
// edge. Directed literal checks pin the model; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_gpio_n;

  localparam int          PINS = 32;
  localparam logic [31:0] BASE = 32'h4000_1200;
  localparam int          DEB  = 4;
`ifdef GPIO_DEBOUNCE_EN
  localparam int DEB_EXTRA = DEB;
`else
  localparam int DEB_EXTRA = 0;
`endif
  // Falling edges from a pad change until STATUS/c_irq reflects it.
  localparam int NE = 3 + DEB_EXTRA;

  localparam logic [5:0] OFF_OUT    = 6'h00;
  localparam logic [5:0] OFF_DIR    = 6'h01;
  localparam logic [5:0] OFF_IN     = 6'h02;
  localparam logic [5:0] OFF_RISE   = 6'h03;
  localparam logic [5:0] OFF_FALL   = 6'h04;
  localparam logic [5:0] OFF_IRQ_EN = 6'h05;
  localparam logic [5:0] OFF_STATUS = 6'h06;
  localparam logic [5:0] OFF_SET    = 6'h07;
  localparam logic [5:0] OFF_CLR    = 6'h08;

  typedef struct {
    logic [31:0] out, dir, rise, fall, irqen, status;
    logic [31:0] s1, s2, prev, deb;
    int          cnt [32];
    logic        ready;
    logic [31:0] data;
  } mstate_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_addr  = '0;
  logic [31:0] wr_data  = '0;
  logic [3:0]  wr_strb  = '0;
  logic        rd_valid = 1'b0;
  logic [31:0] rd_addr  = '0;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        irq;
  logic [31:0] tb_val = '0;
  wire  [31:0] pads;

  mstate_t m;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Bench drives every pin the model says is an input.
  for (genvar i = 0; i < PINS; i++) begin : g_drv
    assign pads[i] = m.dir[i] ? 1'bz : tb_val[i];
  end

  gpio_n #(.PINS(PINS), .ADDR_BASE(BASE), .DEB_CYCLES(DEB)) dut (
    .clk                    (clk),
    .c_sys_rst_n            (rst_n),
    .b_data_io              (pads),
    .ic0_c_axi_mst_wr_valid (wr_valid),
    .ic0_axi_mst_wr_addr    (wr_addr),
    .ic0_axi_mst_wr_data    (wr_data),
    .ic0_axi_mst_wr_strobe  (wr_strb),
    .ic0_c_axi_mst_rd_valid (rd_valid),
    .ic0_axi_mst_rd_addr    (rd_addr),
    .ic0_c_axi_slv_rd_ready (rd_ready),
    .ic0_axi_slv_rd_data    (rd_data),
    .c_irq                  (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ------------------------------ model -----------------------------------
  function automatic mstate_t reset_state();
    mstate_t z;
    z.out = '0; z.dir = '0; z.rise = '0; z.fall = '0; z.irqen = '0; z.status = '0;
    z.s1 = '0; z.s2 = '0; z.prev = '0; z.deb = '0;
    for (int i = 0; i < 32; i++) z.cnt[i] = 0;
    z.ready = 1'b0;
    z.data  = '0;
    return z;
  endfunction

  function automatic logic [31:0] model_read(input mstate_t s, input logic [5:0] off,
                                            input logic [31:0] lvl);
    case (off)
      OFF_OUT:    return s.out;
      OFF_DIR:    return s.dir;
      OFF_IN:     return lvl;
      OFF_RISE:   return s.rise;
      OFF_FALL:   return s.fall;
      OFF_IRQ_EN: return s.irqen;
      OFF_STATUS: return s.status;
      default:    return 32'h0;
    endcase
  endfunction

  function automatic mstate_t model_step(input mstate_t s, input logic [31:0] pad_in,
                                         input logic wv, input logic [31:0] wa,
                                         input logic [31:0] wd, input logic [3:0] ws,
                                         input logic rv, input logic [31:0] ra);
    mstate_t     n;
    logic [31:0] lvl, rise, fall, mask, bits, w1c;
    n = s;
`ifdef GPIO_DEBOUNCE_EN
    lvl = s.deb;
    for (int i = 0; i < 32; i++) begin
      if (s.s2[i] != s.deb[i]) begin
        n.cnt[i] = s.cnt[i] + 1;
        if (n.cnt[i] == DEB) begin
          n.deb[i] = s.s2[i];
          n.cnt[i] = 0;
        end
      end else begin
        n.cnt[i] = 0;
      end
    end
`else
    lvl = s.s2;
`endif
    rise = lvl & ~s.prev & s.rise;
    fall = ~lvl & s.prev & s.fall;
    n.ready = rv && (ra[31:8] == BASE[31:8]);
    n.data  = n.ready ? model_read(s, ra[7:2], lvl) : 32'h0;
    w1c = '0;
    if (wv && (wa[31:8] == BASE[31:8])) begin
      mask = {{8{ws[3]}}, {8{ws[2]}}, {8{ws[1]}}, {8{ws[0]}}};
      bits = wd & mask;
      case (wa[7:2])
        OFF_OUT:    n.out   = (s.out   & ~mask) | bits;
        OFF_DIR:    n.dir   = (s.dir   & ~mask) | bits;
        OFF_RISE:   n.rise  = (s.rise  & ~mask) | bits;
        OFF_FALL:   n.fall  = (s.fall  & ~mask) | bits;
        OFF_IRQ_EN: n.irqen = (s.irqen & ~mask) | bits;
        OFF_STATUS: w1c     = bits;
        OFF_SET:    n.out   = s.out | bits;
        OFF_CLR:    n.out   = s.out & ~bits;
        default:    ;
      endcase
    end
    n.status = (s.status & ~w1c) | rise | fall;
    n.prev   = lvl;
    n.s2     = s.s1;
    n.s1     = pad_in;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= reset_state();
    else        m <= model_step(m, (m.dir & m.out) | (~m.dir & tb_val),
                                wr_valid, wr_addr, wr_data, wr_strb, rd_valid, rd_addr);
  end

  // Compare process
  always @(negedge clk) begin
    if (rst_n) begin
      check("rd_ready", 32'(rd_ready), 32'(m.ready));
      check("rd_data",  rd_data, m.data);
      check("c_irq",    32'(irq), 32'(|(m.status & m.irqen)));
      check("pads_out", pads & m.dir, m.out & m.dir);
    end
  end

  // ---------------------------- stimulus ----------------------------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write_addr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic bus_write(input logic [5:0] off, input logic [31:0] d);
    bus_write_addr({BASE[31:8], off, 2'b00}, d, 4'hF);
  endtask

  task automatic bus_read(input logic [5:0] off, output logic [31:0] d);
    rd_valid = 1'b1; rd_addr = {BASE[31:8], off, 2'b00};
    @(negedge clk);
    rd_valid = 1'b0;
    check("rd_ready pulse", 32'(rd_ready), 32'd1);
    d = rd_data;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] b;
    logic [5:0]  off;
    b   = ($urandom_range(0, 7) == 0) ? $urandom : BASE;
    off = 6'($urandom_range(0, 10));
    return {b[31:8], off, 2'($urandom_range(0, 3))};
  endfunction

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;

    // Reset: DUT must not drive any pad.
    #2 rst_n = 1'b0;
    tb_val = 32'hC3C3_5A5A;
    idle(3);
    check("reset rd_ready", 32'(rd_ready), 32'd0);
    check("reset rd_data",  rd_data, 32'd0);
    check("reset c_irq",    32'(irq), 32'd0);
    check("reset pads undriven", pads, 32'hC3C3_5A5A);
    tb_val = '0;
    idle(1);
    rst_n = 1'b1;
    idle(2);
    for (int o = 0; o <= 8; o++) begin
      bus_read(6'(o), v);
      check($sformatf("reset read 0x%02h", o * 4), v, 32'd0);
    end

    // Output path and SET/CLR
    bus_write(OFF_DIR, 32'h0000_00FF);
    bus_write(OFF_OUT, 32'h0000_00A5);
    bus_write(OFF_SET, 32'h0000_0002);
    bus_write(OFF_CLR, 32'h0000_0080);
    check("pads after set/clr", pads & 32'hFF, 32'h27);
    bus_read(OFF_OUT, v);
    check("OUT after set/clr", v, 32'h27);
    bus_read(OFF_SET, v);
    check("SET reads 0", v, 32'h0);
    idle(NE);
    bus_read(OFF_IN, v);
    check("IN readback of outputs", v, 32'h27);

    // Byte strobes and out-of-window write
    bus_write(OFF_OUT, 32'h0);
    bus_write_addr({BASE[31:8], OFF_OUT, 2'b00}, 32'h1234_5678, 4'b0001);
    bus_read(OFF_OUT, v);
    check("OUT strobe 0001", v, 32'h0000_0078);
    bus_write_addr(BASE + 32'h100, 32'hFFFF_FFFF, 4'hF);
    bus_read(OFF_OUT, v);
    check("OUT miss ignored", v, 32'h0000_0078);
    bus_write_addr({BASE[31:8], OFF_OUT, 2'b11}, 32'h1234_5678, 4'b1010);
    bus_read(OFF_OUT, v);
    check("OUT strobe 1010", v, 32'h1200_5678);

    // Rising edge -> STATUS -> c_irq, exact latency, then W1C
    bus_write(OFF_DIR, 32'h0);
    bus_write(OFF_OUT, 32'h0);
    bus_write(OFF_RISE, 32'h1);
    bus_write(OFF_IRQ_EN, 32'h1);
    idle(NE + 2);
    tb_val[0] = 1'b1;
    for (int k = 1; k <= NE; k++) begin
      @(negedge clk);
      check($sformatf("irq latency step %0d", k), 32'(irq), (k == NE) ? 32'd1 : 32'd0);
    end
    bus_read(OFF_STATUS, v);
    check("STATUS after rise", v, 32'h1);
    bus_write(OFF_STATUS, 32'h1);
    check("c_irq after W1C", 32'(irq), 32'd0);
    bus_read(OFF_STATUS, v);
    check("STATUS after W1C", v, 32'h0);

    // W1C colliding with a fresh falling edge: the edge wins
    bus_write(OFF_FALL, 32'h1);
    idle(2);
    tb_val[0] = 1'b0;
    idle(NE - 1);
    bus_write(OFF_STATUS, 32'h1);
    check("c_irq edge beats W1C", 32'(irq), 32'd1);
    bus_read(OFF_STATUS, v);
    check("STATUS edge beats W1C", v, 32'h1);
    bus_write(OFF_FALL, 32'h0);
    bus_write(OFF_RISE, 32'h0);
    bus_write(OFF_DIR, 32'hF0);
    bus_read(OFF_STATUS, v);
    check("STATUS kept on enable change", v, 32'h1);
    bus_write(OFF_STATUS, 32'hFFFF_FFFF);
    bus_write(OFF_DIR, 32'h0);
    check("c_irq cleared", 32'(irq), 32'd0);

    // Reset during a pending read response
    rd_valid = 1'b1; rd_addr = {BASE[31:8], OFF_IRQ_EN, 2'b00};
    @(posedge clk);
    #1;
    check("pending rd_ready", 32'(rd_ready), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rd_ready dropped on reset", 32'(rd_ready), 32'd0);
    check("rd_data dropped on reset",  rd_data, 32'd0);
    @(negedge clk);
    rd_valid = 1'b0;
    tb_val = '0;
    idle(1);
    rst_n = 1'b1;
    idle(2);
    bus_read(OFF_IRQ_EN, v);
    check("IRQ_EN after reset", v, 32'h0);

`ifdef GPIO_DEBOUNCE_EN
    // Glitch shorter than DEB is rejected, longer pulse is accepted
    tb_val[1] = 1'b1;
    idle(3);
    tb_val[1] = 1'b0;
    idle(12);
    bus_read(OFF_IN, v);
    check("debounce glitch rejected", v & 32'h2, 32'h0);
    tb_val[1] = 1'b1;
    idle(6);
    bus_read(OFF_IN, v);
    check("debounce pulse accepted", v & 32'h2, 32'h2);
    tb_val[1] = 1'b0;
    idle(12);
`endif

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_addr  = rand_addr();
      wr_data  = $urandom;
      wr_strb  = 4'($urandom_range(0, 15));
      rd_valid = ($urandom_range(0, 1) == 0);
      rd_addr  = rand_addr();
      if ($urandom_range(0, 5) == 0) tb_val[$urandom_range(0, 31)] ^= 1'b1;
      if ($urandom_range(0, 199) == 0) tb_val = $urandom;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
